// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, I-type opcodes and issue payload types
package alu_pkg;

  // ALU function codes (identical to the R-type funct field)
  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;
  localparam logic [5:0] ALU_XOR = 6'h26;
  localparam logic [5:0] ALU_SLT = 6'h2a;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  // How operand B is formed: rt operand, or the immediate sign/zero extended
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_mode_e;

  // One issued operation as held in the output and skid registers
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  alu_ops;
    logic [4:0]  dest_reg;
    logic        dest_we;
    logic        illegal;
  } issue_pkt_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input imm_mode_e mode);
    if (mode == IMM_SEXT) return {{16{imm[15]}}, imm};
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational instruction decode for the ALU issue stage
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  alu_ops_o,
  output imm_mode_e   imm_mode_o,
  output logic [4:0]  dest_reg_o,
  output logic        dest_we_o,
  output logic        illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt_idx;
  logic [4:0] rd_idx;
  logic       unused_shamt;

  assign opcode       = instr_i[31:26];
  assign rt_idx       = instr_i[20:16];
  assign rd_idx       = instr_i[15:11];
  assign funct        = instr_i[5:0];
  assign unused_shamt = ^{instr_i[25:21], instr_i[10:6]};

  // Map opcode/funct to function code, B source and destination; anything else is illegal
  always_comb begin
    alu_ops_o  = ALU_NOP;
    imm_mode_o = IMM_NONE;
    dest_reg_o = 5'd0;
    illegal_o  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dest_reg_o = rd_idx;
        case (funct)
          ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT: alu_ops_o = funct;
          default: begin
            illegal_o  = 1'b1;
            dest_reg_o = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin alu_ops_o = ALU_ADD; imm_mode_o = IMM_SEXT; dest_reg_o = rt_idx; end
      OP_SLTI: begin alu_ops_o = ALU_SLT; imm_mode_o = IMM_SEXT; dest_reg_o = rt_idx; end
      OP_ANDI: begin alu_ops_o = ALU_AND; imm_mode_o = IMM_ZEXT; dest_reg_o = rt_idx; end
      OP_ORI:  begin alu_ops_o = ALU_OR;  imm_mode_o = IMM_ZEXT; dest_reg_o = rt_idx; end
      OP_XORI: begin alu_ops_o = ALU_XOR; imm_mode_o = IMM_ZEXT; dest_reg_o = rt_idx; end
      default: illegal_o = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded, so never request them
    dest_we_o = !illegal_o && (dest_reg_o != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - registered ALU operand-issue stage with forwarding (ALU_ISSUE_FWD_EN) and skid buffer
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_we,
  input  logic [4:0]  ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        mem_we,
  input  logic [4:0]  mem_wreg,
  input  logic [31:0] mem_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        Cin,
  output logic [5:0]  alu_ops,
  output logic [4:0]  dest_reg,
  output logic        dest_we,
  output logic        illegal
);

  logic [5:0]  dec_alu_ops;
  imm_mode_e   dec_imm_mode;
  logic [4:0]  dec_dest_reg;
  logic        dec_dest_we;
  logic        dec_illegal;

  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  issue_pkt_t  new_pkt;

  issue_pkt_t  out_q, out_d;
  issue_pkt_t  skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept;

  alu_issue_decode u_decode (
    .instr_i    (instr),
    .alu_ops_o  (dec_alu_ops),
    .imm_mode_o (dec_imm_mode),
    .dest_reg_o (dec_dest_reg),
    .dest_we_o  (dec_dest_we),
    .illegal_o  (dec_illegal)
  );

  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];

`ifdef ALU_ISSUE_FWD_EN
  // Newest producer wins: execute result, then memory result, then register file
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf,
                                          input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                          input logic mw, input logic [4:0] mr, input logic [31:0] md);
    if (idx == 5'd0) return 32'd0;
    if (ew && (er == idx)) return ed;
    if (mw && (mr == idx)) return md;
    return rf;
  endfunction

  assign rs_val = resolve(rs_idx, rs_data, ex_we, ex_wreg, ex_wdata, mem_we, mem_wreg, mem_wdata);
  assign rt_val = resolve(rt_idx, rt_data, ex_we, ex_wreg, ex_wdata, mem_we, mem_wreg, mem_wdata);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_we, ex_wreg, ex_wdata, mem_we, mem_wreg, mem_wdata};
  assign rs_val = (rs_idx == 5'd0) ? 32'd0 : rs_data;
  assign rt_val = (rt_idx == 5'd0) ? 32'd0 : rt_data;
`endif

  // Assemble the payload captured on accept
  always_comb begin
    new_pkt          = '0;
    new_pkt.a        = rs_val;
    new_pkt.b        = (dec_imm_mode == IMM_NONE) ? rt_val : ext_imm(instr[15:0], dec_imm_mode);
    new_pkt.alu_ops  = dec_alu_ops;
    new_pkt.dest_reg = dec_dest_reg;
    new_pkt.dest_we  = dec_dest_we;
    new_pkt.illegal  = dec_illegal;
  end

  // in_ready is the inverted skid-valid flop, so it never depends on out_ready combinationally
  assign accept = in_valid && !skid_valid_q;

  // Skid-buffer next state: flush dominates, skid drains before new input, hold keeps payload
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_pkt;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_pkt;
      skid_valid_d = 1'b1;
    end
  end

  // Output and skid registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign A         = out_q.a;
  assign B         = out_q.b;
  assign Cin       = 1'b0;
  assign alu_ops   = out_q.alu_ops;
  assign dest_reg  = out_q.dest_reg;
  assign dest_we   = out_q.dest_we;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] instr, rs_data, rt_data;
  logic        ex_we, mem_we;
  logic [4:0]  ex_wreg, mem_wreg;
  logic [31:0] ex_wdata, mem_wdata;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic        Cin;
  logic [5:0]  alu_ops;
  logic [4:0]  dest_reg;
  logic        dest_we, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .ex_we(ex_we), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .Cin(Cin), .alu_ops(alu_ops),
    .dest_reg(dest_reg), .dest_we(dest_we), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs_data = '0; rt_data = '0;
    ex_we = 1'b0; ex_wreg = '0; ex_wdata = '0;
    mem_we = 1'b0; mem_wreg = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_Cin", Cin, 0);
    check("rst_alu_ops", alu_ops, 0);
    check("rst_dest_reg", dest_reg, 0);
    check("rst_dest_we", dest_we, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    tick();

    // add $3,$1,$2
    in_valid = 1'b1; instr = rtype(1, 2, 3, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
    tick();
    check("add_valid", out_valid, 1);
    check("add_A", A, 5);
    check("add_B", B, 7);
    check("add_ops", alu_ops, 6'h20);
    check("add_dest", dest_reg, 3);
    check("add_we", dest_we, 1);
    check("add_illegal", illegal, 0);
    check("add_Cin", Cin, 0);

    // addi $4,$1,-1
    instr = itype(6'h08, 1, 4, 16'hFFFF); rs_data = 32'h10; rt_data = 32'h99;
    tick();
    check("addi_B", B, 32'hFFFF_FFFF);
    check("addi_ops", alu_ops, 6'h20);
    check("addi_dest", dest_reg, 4);
    check("addi_A", A, 32'h10);

    // ori $4,$1,0xFFFF
    instr = itype(6'h0d, 1, 4, 16'hFFFF);
    tick();
    check("ori_B", B, 32'h0000_FFFF);
    check("ori_ops", alu_ops, 6'h25);

    // slti $6,$2,0x8000
    instr = itype(6'h0a, 2, 6, 16'h8000);
    tick();
    check("slti_B", B, 32'hFFFF_8000);
    check("slti_ops", alu_ops, 6'h2a);
    check("slti_dest", dest_reg, 6);

    // andi / xori zero-extend
    instr = itype(6'h0c, 2, 7, 16'h8001);
    tick();
    check("andi_B", B, 32'h0000_8001);
    check("andi_ops", alu_ops, 6'h24);
    instr = itype(6'h0e, 2, 8, 16'hF00F);
    tick();
    check("xori_B", B, 32'h0000_F00F);
    check("xori_ops", alu_ops, 6'h26);

    // sub $9,$3,$4
    instr = rtype(3, 4, 9, 6'h22); rs_data = 32'h1234; rt_data = 32'h5678;
    tick();
    check("sub_A", A, 32'h1234);
    check("sub_B", B, 32'h5678);
    check("sub_ops", alu_ops, 6'h22);

    // forwarding: ex and mem both write $2
    ex_we = 1'b1; ex_wreg = 5'd2; ex_wdata = 32'hAA;
    mem_we = 1'b1; mem_wreg = 5'd2; mem_wdata = 32'hBB;
    instr = rtype(2, 3, 5, 6'h20); rs_data = 32'h11; rt_data = 32'h22;
    tick();
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_ex_A", A, 32'hAA);
`else
    check("fwd_ex_A", A, 32'h11);
`endif
    check("fwd_ex_B", B, 32'h22);

    // rs=0 always reads zero
    instr = rtype(0, 3, 5, 6'h20);
    ex_wreg = 5'd0; mem_wreg = 5'd0;
    tick();
    check("fwd_zero_A", A, 0);

    // only mem matches (on rt)
    ex_wreg = 5'd9; mem_wreg = 5'd3;
    instr = rtype(2, 3, 5, 6'h20);
    tick();
    check("fwd_mem_A", A, 32'h11);
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_mem_B", B, 32'hBB);
`else
    check("fwd_mem_B", B, 32'h22);
`endif
    ex_we = 1'b0; mem_we = 1'b0;

    // illegal funct and opcode
    instr = rtype(1, 2, 3, 6'h27); rs_data = 32'd9;
    tick();
    check("ill_funct_ops", alu_ops, 0);
    check("ill_funct_flag", illegal, 1);
    check("ill_funct_we", dest_we, 0);
    check("ill_funct_valid", out_valid, 1);
    instr = itype(6'h23, 1, 2, 16'h0004);
    tick();
    check("ill_op_flag", illegal, 1);
    check("ill_op_ops", alu_ops, 0);
    check("ill_op_we", dest_we, 0);

    // add $0,$1,$2
    instr = rtype(1, 2, 0, 6'h20);
    tick();
    check("r0_we", dest_we, 0);
    check("r0_illegal", illegal, 0);
    check("r0_ops", alu_ops, 6'h20);
    in_valid = 1'b0;
    tick();
    check("idle_valid", out_valid, 0);

    // backpressure: 3 ops offered while out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1; instr = rtype(1, 2, 11, 6'h20); rs_data = 32'h101;
    tick();
    check("bp1_valid", out_valid, 1);
    check("bp1_dest", dest_reg, 11);
    check("bp1_ready", in_ready, 1);
    instr = rtype(1, 2, 12, 6'h20); rs_data = 32'h102;
    tick();
    check("bp2_ready", in_ready, 0);
    check("bp2_dest", dest_reg, 11);
    instr = rtype(1, 2, 13, 6'h20); rs_data = 32'h103;
    tick();
    check("bp3_ready", in_ready, 0);
    check("bp3_hold_dest", dest_reg, 11);
    check("bp3_hold_A", A, 32'h101);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_dest", dest_reg, 12);
    check("bp_rel1_A", A, 32'h102);
    check("bp_rel1_ready", in_ready, 1);
    tick();
    check("bp_rel2_dest", dest_reg, 13);
    check("bp_rel2_A", A, 32'h103);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);

    // flush with skid full, op presented in the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1; instr = rtype(1, 2, 21, 6'h20);
    tick();
    instr = rtype(1, 2, 22, 6'h20);
    tick();
    check("fl_full_ready", in_ready, 0);
    flush = 1'b1; instr = rtype(1, 2, 23, 6'h20);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl_after_valid", out_valid, 0);

    // flush while in_ready=1 discards the same-cycle accept
    out_ready = 1'b0;
    in_valid = 1'b1; instr = rtype(1, 2, 24, 6'h20);
    tick();
    flush = 1'b1; instr = rtype(1, 2, 25, 6'h20);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", out_valid, 0);
    check("fl2_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl2_after_valid", out_valid, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; instr = rtype(1, 2, 26, 6'h20); rs_data = 32'h77;
    tick();
    instr = rtype(1, 2, 27, 6'h20);
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_A", A, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_after_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered operand-issue stage directly upstream of the ALU. It decodes the instruction word into the ALU's 6-bit function code, selects and extends operands, and resolves read-after-write hazards by forwarding. It hands one operation per cycle to the execute stage over a valid/ready handshake with a one-entry skid buffer.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low (fixed).
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept.
- `instr` in 32: instruction word.
- `rs_data` in 32: register-file read, port rs.
- `rt_data` in 32: register-file read, port rt.
- `ex_we`, `ex_wreg[4:0]`, `ex_wdata[31:0]` in: execute-stage result, newer.
- `mem_we`, `mem_wreg[4:0]`, `mem_wdata[31:0]` in: memory-stage result, older.
- `out_valid` out 1: issued op present.
- `out_ready` in 1: ALU stage accepts.
- `A`, `B` out 32: ALU operands.
- `Cin` out 1: ALU carry-in; always 0.
- `alu_ops` out 6: ALU function code.
- `dest_reg` out 5: write-back register.
- `dest_we` out 1: write-back enable.
- `illegal` out 1: unsupported instruction.

## Operation
- R-type (opcode 0): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2a SLT.
  - `alu_ops`=funct; `B`=rt operand; `dest_reg`=rd.
- I-type, `dest_reg`=rt:
  - 0x08 addi→ADD, sign-extended immediate.
  - 0x0a slti→SLT, sign-extended immediate.
  - 0x0c andi→AND, zero-extended immediate.
  - 0x0d ori→OR, zero-extended immediate.
  - 0x0e xori→XOR, zero-extended immediate.
- Any other opcode/funct:
  - `alu_ops`=0x00, so the ALU outputs 0.
  - `dest_we`=0; `illegal`=1.
  - The op is still issued, never dropped.
- `dest_we`=1 only for legal ops with `dest_reg`≠0.
- Forwarding, per source index (rs, rt):
  - Index 0 reads 0.
  - Else the `ex` match wins; else the `mem` match; else the register-file data.
  - A match requires `*_we`=1 and an equal index.
  - Resolved only at capture. Upstream stalls producers while this stage holds entries.
- Buffer: output register plus skid register.
  - `in_ready` = skid empty, registered.
  - Accept (`in_valid`&`in_ready`) with output empty, or output draining (`out_ready`): load the output register.
  - Accept while output held (`out_valid`&~`out_ready`): load skid.
  - When output drains and skid full: skid moves to output, skid empties.
  - Simultaneous accept + drain + skid full cannot occur because `in_ready`=0.
- `flush`:
  - Clears output and skid valid bits next edge.
  - Overrides capture and transfer in the same cycle.
  - `in_ready`=1 the next cycle.

## Timing
- Latency 1 cycle from accept to `out_valid`; throughput 1 op/cycle with `out_ready` held high.
- Reset values: `out_valid`=0, `in_ready`=1, `A`=`B`=0, `Cin`=0, `alu_ops`=0, `dest_reg`=0, `dest_we`=0, `illegal`=0, skid empty.
- Reset mid-operation discards both entries asynchronously.
- All outputs are register-driven; no combinational path from `out_ready` to `in_ready`.
- Output payload is stable while `out_valid`&~`out_ready`.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as above.
- Undefined:
  - `ex_*`/`mem_*` inputs are ignored and operands come straight from `rs_data`/`rt_data` (index 0 still reads 0).
  - Hazards become upstream's responsibility.

## Structure
- Shared package `alu_pkg`: ALU function-code constants (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2a) and I-type opcode constants, for reuse by the ALU and this stage.
- One combinational sub-module `alu_issue_decode`: instr → `alu_ops`, immediate-select/extend mode, `dest_reg`, `dest_we`, `illegal`.
- Forwarding muxes and the skid buffer live in the top.

## Test plan
- Reset, then `add $3,$1,$2` with rs=5, rt=7 → next cycle `out_valid`=1, A=5, B=7, `alu_ops`=0x20, `dest_reg`=3, `dest_we`=1.
- `addi $4,$1,-1` (imm 0xFFFF) → B=0xFFFFFFFF. `ori $4,$1,0xFFFF` → B=0x0000FFFF, `alu_ops`=0x25.
- rs=2 with `ex_wreg`=2 (0xAA) and `mem_wreg`=2 (0xBB), both enabled → A=0xAA. Same case with rs=0 → A=0. Without `ALU_ISSUE_FWD_EN` → A=`rs_data`.
- `out_ready`=0 for 3 cycles while feeding 3 ops:
  - 2 accepted, `in_ready`=0 from cycle 2.
  - On release the ops emerge in order, with no loss or duplication.
- Skid full plus `flush`=1 → next cycle `out_valid`=0, `in_ready`=1. The `in_valid` op presented in the flush cycle is discarded.
- funct 0x27 → `alu_ops`=0, `illegal`=1, `dest_we`=0. `add $0,...` → `dest_we`=0, `illegal`=0.
